branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Consumes the z/c/n/v flags produced by the ALU and owns the program counter of the 8-bit accumulator core.
- Latches flags on an explicit write strobe and resolves conditional and unconditional branches through a loadable 16-entry target table.
- Inserts a one-cycle bubble after every taken branch.
- Controls start, halt and restart of the core.

Parameters:
- PC_W, 10, program counter width; the PC wraps modulo 2^PC_W.
- START_PC, 0, PC value on reset and on restart.

Ports:
- clk  in  1  single core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE or HALT and begins execution at START_PC.
- step_valid  in  1  one instruction retires this cycle; its br_op and br_idx are valid.
- br_op  in  3  branch operation of the retiring instruction.
- br_idx  in  4  index into the target table.
- halt_req  in  1  the retiring instruction is HALT.
- flag_we  in  1  latch z_in, c_in, n_in and v_in this cycle.
- z_in, c_in, n_in, v_in  in  1 each  flags from the ALU.
- lut_we  in  1  write to the target table.
- lut_waddr  in  4  target table write index.
- lut_wdata  in  PC_W  target table write data.
- pc  out  PC_W  current program counter.
- taken  out  1  registered; 1 for the cycle after a taken branch.
- busy  out  1  1 in IDLE, BUBBLE and HALT; the fetch stage must not assert step_valid while busy=1.
- done  out  1  1 in HALT.
- flags  out  4  latched flags, ordered {z,c,n,v}.

Behaviour:
- Reset (synchronous, active-high) has priority over every other input.
  - pc=START_PC, flags=0, taken=0, done=0.
  - State goes to IDLE (busy=1).
  - Table contents are not reset.
- Reset mid-branch or mid-bubble discards the pending branch entirely.
- States: IDLE, RUN, BUBBLE, HALT.
  - IDLE: start -> RUN with pc=START_PC. Other inputs are ignored, except flag_we and lut_we.
  - RUN: when step_valid=1, resolve the retiring instruction in this priority order:
    - halt_req=1 -> HALT. pc holds and done=1 from the next cycle; br_op is ignored.
    - Condition true -> pc<=table[br_idx], taken<=1, state -> BUBBLE.
    - Otherwise -> pc<=pc+1 (wraps from 2^PC_W-1 to 0), taken<=0.
  - RUN with step_valid=0: pc holds and taken<=0.
  - BUBBLE: lasts exactly 1 cycle; step_valid is ignored. Returns to RUN with taken<=0.
  - HALT: start -> RUN with pc=START_PC and done<=0. Without start the block stays in HALT.
- br_op encoding (condition evaluated on the effective flags):
  - 000 none
  - 001 JMP (always)
  - 010 BEQ (z)
  - 011 BNE (!z)
  - 100 BLT (n)
  - 101 BGE (!n)
  - 110 BCS (c)
  - 111 BVS (v)
- Effective flags:
  - If flag_we=1 in the same cycle as step_valid, the condition uses z_in/c_in/n_in/v_in (bypass). Otherwise it uses the latched flags.
  - flag_we updates all four latched flags in any state, including IDLE, BUBBLE and HALT.
- Target table: 16 x PC_W registers, written synchronously when lut_we=1, in any state.
  - Read is combinational from the pre-edge contents.
  - A same-cycle write and branch to the same index uses the old value; the new value is visible from the next cycle.
- Latency: pc for the next instruction is valid 1 cycle after step_valid. A taken branch costs 2 cycles until the next step is accepted.
- The block contains no latches; all state is in flops clocked by clk.

Decomposition:
- Package branch_pkg holds:
  - enum br_op_t: BR_NONE, BR_JMP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_CS, BR_VS.
  - enum bu_state_t: IDLE, RUN, BUBBLE, HALT.
  - A flag index localparam for the {z,c,n,v} order.
- One sub-module, branch_target_lut: 16-entry register file with a synchronous write port and a combinational read port.
- Condition evaluation and the FSM stay in branch_unit.

Test Plan:
- Reset, then start; retire 3 steps with br_op=000 -> pc goes 0,1,2,3; taken=0 throughout; busy=0 in RUN.
- table[5]=0x120, flag_we with z=1, then BEQ idx 5 -> pc=0x120 and taken=1 the next cycle; busy=1 for 1 cycle; a step_valid during BUBBLE is ignored (pc stays 0x120).
- flag_we with n=0 latched, then step BLT asserted together with flag_we and n_in=1 -> taken via bypass; with n_in=0 -> pc+1.
- Write table[3]=0x050 and branch JMP idx 3 in the same cycle (old value 0x010) -> pc=0x010; a later JMP idx 3 -> pc=0x050.
- pc=0x3FF with br_op=000 step -> pc=0x000 (wrap at PC_W=10).
- halt_req together with a taken BNE -> HALT, pc unchanged, done=1; start -> pc=START_PC, done=0. A reset asserted in BUBBLE -> IDLE, pc=START_PC, taken=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch unit: branch opcodes, FSM states and flag bit positions.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JMP  = 3'b001,
    BR_EQ   = 3'b010,
    BR_NE   = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_CS   = 3'b110,
    BR_VS   = 3'b111
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } bu_state_t;

  // Bit positions inside the packed {z,c,n,v} flag vector.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int LUT_DEPTH = 16;
  localparam int LUT_AW    = 4;

endpackage

// File: rtl/branch_unit_if.sv
// Fetch/ALU-facing bundle of the branch unit; master drives retire info, slave owns the PC.
interface branch_unit_if import branch_pkg::*; #(
  parameter int PC_W = 10
);
  logic              start;
  logic              step_valid;
  br_op_t            br_op;
  logic [LUT_AW-1:0] br_idx;
  logic              halt_req;
  logic              flag_we;
  logic              z_in, c_in, n_in, v_in;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic              busy;
  logic              done;
  logic [3:0]        flags;

  modport master (
    output start, step_valid, br_op, br_idx, halt_req,
    output flag_we, z_in, c_in, n_in, v_in,
    output lut_we, lut_waddr, lut_wdata,
    input  pc, taken, busy, done, flags
  );

  modport slave (
    input  start, step_valid, br_op, br_idx, halt_req,
    input  flag_we, z_in, c_in, n_in, v_in,
    input  lut_we, lut_waddr, lut_wdata,
    output pc, taken, busy, done, flags
  );
endinterface

// File: rtl/branch_target_lut.sv
// 16-entry branch target register file: synchronous write, combinational read of pre-edge contents.
module branch_target_lut import branch_pkg::*; #(
  parameter int PC_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);
  // Contents are deliberately not reset; software loads the table before use.
  logic [LUT_DEPTH-1:0][PC_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/branch_unit.sv
// PC owner of the accumulator core: flag latch, branch resolution, bubble insertion, run control.
module branch_unit import branch_pkg::*; #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  branch_unit_if.slave  bus
);
  bu_state_t       state;
  logic [PC_W-1:0] pc_q;
  logic            taken_q;
  logic [3:0]      flags_q;
  logic [3:0]      eff_flags;
  logic [PC_W-1:0] tgt;
  logic            cond;

  branch_target_lut #(.PC_W(PC_W)) u_lut (
    .clk   (clk),
    .we    (bus.lut_we),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.br_idx),
    .rdata (tgt)
  );

  // Same-cycle flag write bypasses the latch so the retiring branch sees fresh ALU flags.
  assign eff_flags = bus.flag_we ? {bus.z_in, bus.c_in, bus.n_in, bus.v_in} : flags_q;

  always_comb begin
    cond = 1'b0;
    case (bus.br_op)
      BR_NONE: cond = 1'b0;
      BR_JMP:  cond = 1'b1;
      BR_EQ:   cond = eff_flags[FLAG_Z];
      BR_NE:   cond = ~eff_flags[FLAG_Z];
      BR_LT:   cond = eff_flags[FLAG_N];
      BR_GE:   cond = ~eff_flags[FLAG_N];
      BR_CS:   cond = eff_flags[FLAG_C];
      BR_VS:   cond = eff_flags[FLAG_V];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= START_PC;
      taken_q <= 1'b0;
      flags_q <= '0;
    end else begin
      if (bus.flag_we) flags_q <= {bus.z_in, bus.c_in, bus.n_in, bus.v_in};
      taken_q <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (bus.start) begin
            state <= RUN;
            pc_q  <= START_PC;
          end
        end
        RUN: begin
          if (bus.step_valid) begin
            if (bus.halt_req) begin
              state <= HALT;
            end else if (cond) begin
              pc_q    <= tgt;
              taken_q <= 1'b1;
              state   <= BUBBLE;
            end else begin
              pc_q <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
          end
        end
        BUBBLE:  state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc    = pc_q;
  assign bus.taken = taken_q;
  assign bus.busy  = (state != RUN);
  assign bus.done  = (state == HALT);
  assign bus.flags = flags_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: cycle model compared every cycle plus literal spot checks.
module tb_branch_unit;
  import branch_pkg::*;

  localparam int PC_W = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(PC_W)) bus ();
  branch_unit #(.PC_W(PC_W), .START_PC('0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Model: run mode as a small integer, table as plain int array.
  localparam int M_IDLE = 0, M_RUN = 1, M_BUB = 2, M_HALT = 3;
  int m_mode, m_pc, m_taken, m_flags;
  int m_tab [16];
  bit m_valid = 1'b0;

  function automatic bit m_cond(int op, int f);
    bit z, c, n, v;
    z = f[3]; c = f[2]; n = f[1]; v = f[0];
    case (op)
      1: return 1'b1;
      2: return z;
      3: return !z;
      4: return n;
      5: return !n;
      6: return c;
      7: return v;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    int ef;
    ef = bus.flag_we ? {bus.z_in, bus.c_in, bus.n_in, bus.v_in} : m_flags;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_taken = 0; m_flags = 0; m_valid = 1'b1;
    end else begin
      m_taken = 0;
      if (m_mode == M_IDLE || m_mode == M_HALT) begin
        if (bus.start) begin m_mode = M_RUN; m_pc = 0; end
      end else if (m_mode == M_BUB) begin
        m_mode = M_RUN;
      end else if (bus.step_valid) begin
        if (bus.halt_req) m_mode = M_HALT;
        else if (m_cond(int'(bus.br_op), ef)) begin
          m_pc = m_tab[bus.br_idx]; m_taken = 1; m_mode = M_BUB;
        end else m_pc = (m_pc + 1) % PC_MOD;
      end
      if (bus.flag_we) m_flags = ef;
    end
    if (bus.lut_we) m_tab[bus.lut_waddr] = int'(bus.lut_wdata);
  end

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_pc",    int'(bus.pc), m_pc);
      cmp("model_taken", int'(bus.taken), m_taken);
      cmp("model_busy",  int'(bus.busy), int'(m_mode != M_RUN));
      cmp("model_done",  int'(bus.done), int'(m_mode == M_HALT));
      cmp("model_flags", int'(bus.flags), m_flags);
    end
  end

  task automatic clr();
    bus.start = 0; bus.step_valid = 0; bus.br_op = BR_NONE; bus.br_idx = 0;
    bus.halt_req = 0; bus.flag_we = 0; bus.z_in = 0; bus.c_in = 0; bus.n_in = 0;
    bus.v_in = 0; bus.lut_we = 0; bus.lut_waddr = 0; bus.lut_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    clr();
  endtask

  task automatic lut_wr(int idx, int val);
    bus.lut_we = 1; bus.lut_waddr = 4'(idx); bus.lut_wdata = PC_W'(val);
  endtask

  task automatic step(br_op_t op, int idx);
    bus.step_valid = 1; bus.br_op = op; bus.br_idx = 4'(idx);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_tab[i] = 0;
    clr();
    reset = 1;
    tick(); tick();
    reset = 0;
    cmp("rst_pc", int'(bus.pc), 0);
    cmp("rst_busy", int'(bus.busy), 1);
    cmp("rst_done", int'(bus.done), 0);
    cmp("rst_flags", int'(bus.flags), 0);

    lut_wr(5, 'h120); tick();
    lut_wr(3, 'h010); tick();
    lut_wr(7, 'h3FF); tick();
    cmp("idle_busy", int'(bus.busy), 1);

    bus.start = 1; tick();
    cmp("run_busy", int'(bus.busy), 0);
    cmp("run_pc0", int'(bus.pc), 0);
    for (int i = 1; i <= 3; i++) begin
      step(BR_NONE, 0); tick();
      cmp("seq_pc", int'(bus.pc), i);
      cmp("seq_taken", int'(bus.taken), 0);
    end

    bus.flag_we = 1; bus.z_in = 1; tick();
    cmp("flag_z", int'(bus.flags), 'b1000);
    step(BR_EQ, 5); tick();
    cmp("beq_pc", int'(bus.pc), 'h120);
    cmp("beq_taken", int'(bus.taken), 1);
    cmp("beq_busy", int'(bus.busy), 1);
    step(BR_NONE, 0); tick();
    cmp("bub_pc", int'(bus.pc), 'h120);
    cmp("bub_taken", int'(bus.taken), 0);
    cmp("bub_busy", int'(bus.busy), 0);

    bus.flag_we = 1; tick();
    cmp("flag_clr", int'(bus.flags), 0);
    step(BR_LT, 5); bus.flag_we = 1; bus.n_in = 1; tick();
    cmp("blt_bypass_pc", int'(bus.pc), 'h120);
    cmp("blt_bypass_taken", int'(bus.taken), 1);
    tick();
    step(BR_LT, 5); bus.flag_we = 1; bus.n_in = 0; tick();
    cmp("blt_nt_pc", int'(bus.pc), 'h121);
    cmp("blt_nt_taken", int'(bus.taken), 0);

    step(BR_JMP, 3); lut_wr(3, 'h050); tick();
    cmp("jmp_old_pc", int'(bus.pc), 'h010);
    tick();
    step(BR_JMP, 3); tick();
    cmp("jmp_new_pc", int'(bus.pc), 'h050);
    tick();

    step(BR_JMP, 7); tick();
    cmp("jmp_max_pc", int'(bus.pc), 'h3FF);
    tick();
    step(BR_NONE, 0); tick();
    cmp("wrap_pc", int'(bus.pc), 0);

    step(BR_NONE, 0); tick();
    step(BR_NE, 5); bus.halt_req = 1; tick();
    cmp("halt_pc", int'(bus.pc), 1);
    cmp("halt_done", int'(bus.done), 1);
    cmp("halt_taken", int'(bus.taken), 0);
    tick();
    cmp("halt_hold_pc", int'(bus.pc), 1);
    bus.flag_we = 1; bus.c_in = 1; tick();
    cmp("halt_flag", int'(bus.flags), 'b0100);
    bus.start = 1; tick();
    cmp("restart_pc", int'(bus.pc), 0);
    cmp("restart_done", int'(bus.done), 0);

    step(BR_JMP, 5); tick();
    cmp("pre_rst_pc", int'(bus.pc), 'h120);
    reset = 1; tick(); reset = 0;
    cmp("rst_bub_pc", int'(bus.pc), 0);
    cmp("rst_bub_taken", int'(bus.taken), 0);
    cmp("rst_bub_busy", int'(bus.busy), 1);
    tick();
    cmp("rst_bub_idle_pc", int'(bus.pc), 0);
    cmp("rst_bub_idle_busy", int'(bus.busy), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
